// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared state encoding and constants
// for the SPI-slave to parallel-bus bridge.
package spi_bridge_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } state_t;

  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spi_bus_bridge_if.sv
// spi_bus_bridge_if: valid/ready register bus between
// the bridge (master) and the address decoder (slave).
interface spi_bus_bridge_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) ();
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic bus_we;
  logic bus_valid;
  logic bus_ready;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_valid,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_valid,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: pin synchronisers, sclk edge detect,
// rx/tx shifters and bit counter (SPI mode 0, MSB first).
module spi_shift_engine
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_l,
  input  logic              sclk,
  input  logic              mosi,
  input  logic [DATA_W-1:0] tx_word,
  output logic              miso,
  output logic              miso_oe,
  output logic              word_done,
  output logic [DATA_W-1:0] word,
  output logic              frame_start,
  output logic              frame_end,
  output logic              load_tx
);
  localparam int CW = $clog2(DATA_W);

  logic [SYNC_STAGES-1:0] ss_sy;
  logic [SYNC_STAGES-1:0] sclk_sy;
  logic [SYNC_STAGES-1:0] mosi_sy;
  logic ss_s, sclk_s, mosi_s;
  logic ss_q, sclk_q;
  logic rise, fall;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [CW-1:0] bit_cnt;

  assign ss_s = ss_sy[SYNC_STAGES-1];
  assign sclk_s = sclk_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];

  assign rise = sclk_s & ~sclk_q;
  assign fall = ~sclk_s & sclk_q;
  assign frame_start = ss_q & ~ss_s;
  assign frame_end = ~ss_q & ss_s;

  assign word = {rx_sh, mosi_s};
  assign word_done = rise & miso_oe & ~frame_end &
                     (bit_cnt == CW'(DATA_W - 1));
  // A fall with the counter at zero is the boundary
  // where the next tx word must appear on miso.
  assign load_tx = fall & miso_oe & ~frame_end &
                   (bit_cnt == '0);
  assign miso = tx_sh[DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sy <= '1;
      sclk_sy <= '0;
      mosi_sy <= '0;
      ss_q <= 1'b1;
      sclk_q <= 1'b0;
    end else begin
      ss_sy <= {ss_sy[SYNC_STAGES-2:0], ss_l};
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi};
      ss_q <= ss_s;
      sclk_q <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso_oe <= 1'b0;
      bit_cnt <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
    end else if (frame_start || frame_end) begin
      miso_oe <= frame_start;
      bit_cnt <= '0;
      tx_sh <= '0;
    end else if (miso_oe) begin
      if (rise) begin
        rx_sh <= word[DATA_W-2:0];
        bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      end
      if (load_tx) begin
        tx_sh <= tx_word;
      end else if (fall) begin
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: SPI-slave to valid/ready bus bridge with bursts.
// Optional bus timeout: define SPI_BRIDGE_TIMEOUT_EN.
module spi_bus_bridge
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int AUTO_INC = 1,
  parameter logic [DATA_W-1:0] STALL_DATA = {DATA_W{1'b1}},
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_l,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic overrun,
  output logic busy,
  spi_bus_bridge_if.master bus
);
  localparam logic [ADDR_W-1:0] INC =
    (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  state_t state, state_n;
  logic [DATA_W-1:0] word, tx_word, tx_buf, rdata_in;
  logic [ADDR_W-1:0] addr, rd_addr;
  logic word_done, frame_start, frame_end, load_tx;
  logic cmd_done, cmd_rd, wr_word, rd_issue;
  logic rd_req, tx_full, discard;
  logic bus_done, tmo_hit;

  spi_shift_engine #(.DATA_W(DATA_W)) u_eng (
    .clk        (clk),
    .rst        (rst),
    .ss_l       (ss_l),
    .sclk       (sclk),
    .mosi       (mosi),
    .tx_word    (tx_word),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .word_done  (word_done),
    .word       (word),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .load_tx    (load_tx)
  );

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = bus.bus_valid & ~bus.bus_ready &
                   (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !bus.bus_valid || bus.bus_ready || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign bus_done = bus.bus_valid & (bus.bus_ready | tmo_hit);
  assign rdata_in = tmo_hit ? STALL_DATA : bus.bus_rdata;

  assign cmd_done = word_done & ~frame_start & (state == CMD);
  assign cmd_rd = cmd_done & (word[DATA_W-1] == RW_READ);
  assign wr_word = word_done & (state == WR_DATA);
  assign rd_addr = cmd_rd ? word[ADDR_W-1:0] : addr;
  assign rd_issue = ~bus.bus_valid &
    (cmd_rd | (rd_req & (state == RD_DATA) & ~frame_end));

  assign tx_word = (state != RD_DATA) ? '0 :
                   tx_full ? tx_buf : STALL_DATA;
  assign busy = (state != IDLE) | bus.bus_valid;

  always_comb begin
    state_n = state;
    unique case (1'b1)
      frame_start: state_n = CMD;
      frame_end:   state_n = IDLE;
      cmd_done:    state_n = cmd_rd ? RD_DATA : WR_DATA;
      default:     state_n = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      rd_req <= 1'b0;
      tx_buf <= '0;
      tx_full <= 1'b0;
      discard <= 1'b0;
      overrun <= 1'b0;
      bus.bus_addr <= '0;
      bus.bus_wdata <= '0;
      bus.bus_we <= 1'b0;
      bus.bus_valid <= 1'b0;
    end else begin
      if (bus_done) begin
        bus.bus_valid <= 1'b0;
        discard <= 1'b0;
        if (!bus.bus_we && !discard && state == RD_DATA) begin
          tx_buf <= rdata_in;
          tx_full <= 1'b1;
        end
        if (tmo_hit) overrun <= 1'b1;
      end
      if (cmd_done) addr <= word[ADDR_W-1:0];
      if (rd_issue) begin
        bus.bus_addr <= rd_addr;
        bus.bus_we <= 1'b0;
        bus.bus_valid <= 1'b1;
        addr <= rd_addr + INC;
        rd_req <= 1'b0;
      end else if (cmd_rd) begin
        rd_req <= 1'b1;
      end
      if (wr_word) begin
        addr <= addr + INC;
        if (!bus.bus_valid) begin
          bus.bus_addr <= addr;
          bus.bus_wdata <= word;
          bus.bus_we <= 1'b1;
          bus.bus_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      // Consuming the prefetch triggers the next read.
      if (load_tx && state == RD_DATA) begin
        if (tx_full) begin
          tx_full <= 1'b0;
          rd_req <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (frame_end) begin
        tx_full <= 1'b0;
        rd_req <= 1'b0;
        discard <= bus.bus_valid & ~bus_done;
      end
      if (frame_start) begin
        overrun <= 1'b0;
        tx_full <= 1'b0;
        rd_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb_spi_bus_bridge: directed SPI frames with bus-side
// scoreboards for the spi_bus_bridge.
module tb_spi_bus_bridge;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst, ss_l, sclk, mosi;
  logic miso0, oe0, ovr0, busy0;
  logic miso1, oe1, ovr1, busy1;

  int n_chk = 0;
  int n_pass = 0;
  int lat = 2;
  bit hold = 1'b0;
  int cnt0 = 0;
  int run = 0;
  int first_run = 0;

  logic [14:0] wq[$];
  logic [6:0] rq[$];
  logic [6:0] w1[$];
  logic [7:0] mem[128];

  spi_bus_bridge_if #(.DATA_W(8), .ADDR_W(7)) b0 ();
  spi_bus_bridge_if #(.DATA_W(8), .ADDR_W(7)) b1 ();

  spi_bus_bridge #(.AUTO_INC(1)) u0 (
    .clk(clk), .rst(rst), .ss_l(ss_l), .sclk(sclk),
    .mosi(mosi), .miso(miso0), .miso_oe(oe0),
    .overrun(ovr0), .busy(busy0), .bus(b0)
  );

  spi_bus_bridge #(.AUTO_INC(0)) u1 (
    .clk(clk), .rst(rst), .ss_l(ss_l), .sclk(sclk),
    .mosi(mosi), .miso(miso1), .miso_oe(oe1),
    .overrun(ovr1), .busy(busy1), .bus(b1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic cw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb,
                          input bit last,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      mosi = tx[i];
      cw(H);
      sclk = 1'b1;
      rx = {rx[6:0], miso0};
      cw(H);
      sclk = 1'b0;
      if (last && i == 8 - nb) ss_l = 1'b1;
    end
  endtask

  task automatic ss_begin();
    ss_l = 1'b0;
    cw(H);
  endtask

  // Bus slave for u0: programmable latency, hold stalls.
  always @(negedge clk) begin
    logic [14:0] ew;
    logic [6:0] ea;
    if (rst) begin
      b0.bus_ready = 1'b0;
      cnt0 = 0;
    end else if (b0.bus_ready) begin
      b0.bus_ready = 1'b0;
    end else if (!b0.bus_valid) begin
      cnt0 = 0;
    end else begin
      cnt0++;
      if (cnt0 >= lat && !hold) begin
        cnt0 = 0;
        b0.bus_ready = 1'b1;
        if (b0.bus_we) begin
          ew = (wq.size() != 0) ? wq.pop_front() : 'x;
          check("wr", {b0.bus_addr, b0.bus_wdata}, ew);
        end else begin
          ea = (rq.size() != 0) ? rq.pop_front() : 'x;
          check("rd_addr", b0.bus_addr, ea);
          b0.bus_rdata = mem[b0.bus_addr];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b0.bus_valid) begin
      run++;
    end else begin
      if (run != 0 && first_run == 0) first_run = run;
      run = 0;
    end
  end

  // Bus slave for u1: one-cycle ack, logs write addresses.
  always @(negedge clk) begin
    if (rst || b1.bus_ready) begin
      b1.bus_ready = 1'b0;
    end else if (b1.bus_valid) begin
      b1.bus_ready = 1'b1;
      b1.bus_rdata = 8'h00;
      if (b1.bus_we) w1.push_back(b1.bus_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r0, r1, r2;
    logic [6:0] a0, a1;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3);
    mem[3] = 8'h11;
    mem[4] = 8'h22;
    mem[5] = 8'h33;
    b0.bus_ready = 1'b0;
    b0.bus_rdata = '0;
    b1.bus_ready = 1'b0;
    b1.bus_rdata = '0;
    rst = 1'b1;
    ss_l = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    cw(3);
    check("rst_miso", miso0, 0);
    check("rst_oe", oe0, 0);
    check("rst_valid", b0.bus_valid, 0);
    check("rst_addr", b0.bus_addr, 0);
    check("rst_wdata", b0.bus_wdata, 0);
    check("rst_we", b0.bus_we, 0);
    check("rst_ovr", ovr0, 0);
    check("rst_busy", busy0, 0);
    rst = 1'b0;
    cw(4);

    lat = 2;
    wq.push_back({7'h05, 8'hA1});
    wq.push_back({7'h06, 8'hB2});
    ss_begin();
    spi_bits(8'h05, 8, 1'b0, r0);
    check("wr_oe", oe0, 1);
    spi_bits(8'hA1, 8, 1'b0, r1);
    spi_bits(8'hB2, 8, 1'b1, r2);
    cw(H);
    check("wr_seen", wq.size(), 0);
    check("wr_ovr", ovr0, 0);
    check("wr_busy", busy0, 0);
    check("wr_oe_off", oe0, 0);

    lat = 3;
    rq.push_back(7'h03);
    rq.push_back(7'h04);
    rq.push_back(7'h05);
    ss_begin();
    spi_bits(8'h83, 8, 1'b0, r0);
    spi_bits(8'h00, 8, 1'b0, r1);
    spi_bits(8'h00, 8, 1'b1, r2);
    cw(H);
    check("rd_cmd_miso", r0, 8'h00);
    check("rd_word0", r1, 8'h11);
    check("rd_word1", r2, 8'h22);
    check("rd_seen", rq.size(), 0);
    check("rd_ovr", ovr0, 0);

    lat = 2;
    wq.push_back({7'h7F, 8'h01});
    wq.push_back({7'h00, 8'h02});
    w1.delete();
    ss_begin();
    spi_bits(8'h7F, 8, 1'b0, r0);
    spi_bits(8'h01, 8, 1'b0, r1);
    spi_bits(8'h02, 8, 1'b1, r2);
    cw(H);
    check("wrap_seen", wq.size(), 0);
    check("fix_cnt", w1.size(), 2);
    a0 = (w1.size() > 0) ? w1[0] : 'x;
    a1 = (w1.size() > 1) ? w1[1] : 'x;
    check("fix_addr0", a0, 7'h7F);
    check("fix_addr1", a1, 7'h7F);

`ifdef SPI_BRIDGE_TIMEOUT_EN
    hold = 1'b1;
    first_run = 0;
    ss_begin();
    spi_bits(8'h83, 8, 1'b0, r0);
    spi_bits(8'h00, 8, 1'b1, r1);
    cw(H);
    check("tmo_word", r1, 8'hFF);
    check("tmo_ovr", ovr0, 1);
    check("tmo_len", first_run, 16);
    cw(40);
    hold = 1'b0;
    cw(10);
    check("tmo_idle", busy0, 0);
`else
    hold = 1'b1;
    rq.push_back(7'h03);
    ss_begin();
    spi_bits(8'h83, 8, 1'b0, r0);
    spi_bits(8'h00, 8, 1'b1, r1);
    cw(H);
    check("stall_word", r1, 8'hFF);
    check("stall_ovr", ovr0, 1);
    check("stall_busy", busy0, 1);
    hold = 1'b0;
    cw(10);
    check("stall_idle", busy0, 0);
    check("stall_seen", rq.size(), 0);
`endif

    hold = 1'b1;
    wq.push_back({7'h10, 8'h5A});
    ss_begin();
    check("ovr_clear", ovr0, 0);
    spi_bits(8'h10, 8, 1'b0, r0);
    spi_bits(8'h5A, 8, 1'b0, r1);
    spi_bits(8'h6B, 4, 1'b1, r2);
    cw(H);
    check("abort_oe", oe0, 0);
    check("abort_busy", busy0, 1);
    check("abort_valid", b0.bus_valid, 1);
    check("abort_addr", b0.bus_addr, 7'h10);
    check("abort_wdata", b0.bus_wdata, 8'h5A);
    check("abort_ovr", ovr0, 0);
    hold = 1'b0;
    cw(8);
    check("abort_idle", busy0, 0);
    check("abort_seen", wq.size(), 0);

    hold = 1'b1;
    ss_begin();
    spi_bits(8'h83, 8, 1'b0, r0);
    cw(2);
    check("mrst_pend", b0.bus_valid, 1);
    rst = 1'b1;
    ss_l = 1'b1;
    cw(1);
    check("mrst_valid", b0.bus_valid, 0);
    check("mrst_oe", oe0, 0);
    check("mrst_busy", busy0, 0);
    cw(3);
    rst = 1'b0;
    hold = 1'b0;
    cw(10);
    check("mrst_quiet", b0.bus_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
